// File: rtl/axil_reg_if_rd_ext_pkg.sv
// ----------------------------------------------------------------------------
// axil_reg_if_rd_ext_pkg : shared AXI response codes and width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axil_reg_if_rd_ext_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_resp_fifo.sv
// ----------------------------------------------------------------------------
// axil_resp_fifo : small {data,resp} response FIFO with head/count outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axil_resp_fifo
  import axil_reg_if_rd_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int CNT_W     = clog2_min1(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            push_resp,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            head_resp,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  pop_ok;

  // Explicit wrap keeps non-power-of-two pointer widths (DEPTH=1) correct
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && (count != '0);
  assign {head_data, head_resp} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_data, push_resp};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push && pop_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_reg_if_rd_ext.sv
// ----------------------------------------------------------------------------
// axil_reg_if_rd_ext : AXI-lite read front end driving a register read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axil_reg_if_rd_ext
  import axil_reg_if_rd_ext_pkg::*;
#(
  parameter int         DATA_WIDTH   = 32,
  parameter int         ADDR_WIDTH   = 32,
  parameter int         STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int         TIMEOUT      = 4,
  parameter logic [1:0] TIMEOUT_RESP = AXI_RESP_SLVERR,
  parameter int         R_FIFO_DEPTH = 2,
  parameter int         ALIGN_ADDR   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack,
  output logic                  timeout_evt
);

  localparam int CNT_W     = clog2_min1(TIMEOUT + 1);
  localparam int FCNT_W    = clog2_min1(R_FIFO_DEPTH + 1);
  localparam int ALIGN_LSB = $clog2(STRB_WIDTH);
  localparam bit TO_EN     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FIFO_CAP  = FCNT_W'(R_FIFO_DEPTH);

  logic                  busy;
  logic                  busy_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  ar_fire;
  logic                  to_hit;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_resp;
  logic                  pop;
  logic [FCNT_W-1:0]     fifo_count;
  logic [FCNT_W-1:0]     fcount_nxt;
  logic                  arready_nxt;
  logic [ADDR_WIDTH-1:0] ar_addr_aligned;
  logic                  unused_inputs;

  assign unused_inputs = ^{s_axil_arprot, s_axil_araddr};

  generate
    if (ALIGN_ADDR != 0 && ALIGN_LSB > 0) begin : g_align
      assign ar_addr_aligned = {s_axil_araddr[ADDR_WIDTH-1:ALIGN_LSB], {ALIGN_LSB{1'b0}}};
    end else begin : g_no_align
      assign ar_addr_aligned = s_axil_araddr;
    end
  endgenerate

  assign ar_fire       = s_axil_arvalid && s_axil_arready;
  assign reg_rd_en     = busy;
  assign s_axil_rvalid = (fifo_count != '0);
  assign pop           = s_axil_rvalid && s_axil_rready;

  // Ack has priority; wait freezes the counter so a stalled register never times out
  always_comb begin
    busy_nxt  = busy;
    cnt_nxt   = cnt;
    push      = 1'b0;
    push_data = '0;
    push_resp = AXI_RESP_OKAY;
    to_hit    = 1'b0;
    if (busy) begin
      if (reg_rd_ack) begin
        push      = 1'b1;
        push_data = reg_rd_data;
        busy_nxt  = 1'b0;
      end else if (TO_EN && (cnt == '0) && !reg_rd_wait) begin
        push      = 1'b1;
        push_resp = TIMEOUT_RESP;
        to_hit    = 1'b1;
        busy_nxt  = 1'b0;
      end else if (!reg_rd_wait && (cnt != '0)) begin
        cnt_nxt = cnt - 1'b1;
      end
    end else if (ar_fire) begin
      busy_nxt = 1'b1;
      cnt_nxt  = CNT_LOAD;
    end
  end

  // arready is registered from next-state values so it reserves a FIFO slot for the next read
  always_comb begin
    fcount_nxt = fifo_count;
    if (push && !pop) begin
      fcount_nxt = fifo_count + 1'b1;
    end else if (!push && pop) begin
      fcount_nxt = fifo_count - 1'b1;
    end
    arready_nxt = !busy_nxt && (fcount_nxt < FIFO_CAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      cnt            <= '0;
      s_axil_arready <= 1'b0;
      timeout_evt    <= 1'b0;
      reg_rd_addr    <= '0;
    end else begin
      busy           <= busy_nxt;
      cnt            <= cnt_nxt;
      s_axil_arready <= arready_nxt;
      timeout_evt    <= to_hit;
      if (ar_fire) begin
        reg_rd_addr <= ar_addr_aligned;
      end
    end
  end

  axil_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (R_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .push_resp (push_resp),
    .pop       (pop),
    .head_data (s_axil_rdata),
    .head_resp (s_axil_rresp),
    .count     (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_if_rd_ext.sv
// ----------------------------------------------------------------------------
// tb_axil_reg_if_rd_ext : scoreboard bench for the AXI-lite register read front end
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axil_reg_if_rd_ext;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic        arready, rvalid, reg_en, evt;
  logic [31:0] rdata, reg_addr, reg_data;
  logic [1:0]  rresp;
  logic        reg_wait = 1'b0;
  logic        reg_ack = 1'b0;

  logic        na_arready, na_rvalid, na_en, na_evt;
  logic [31:0] na_rdata, na_reg_addr;
  logic [1:0]  na_rresp;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int evt_cnt = 0;
  int ack_at = 1;
  int wait_len = 0;
  int en_idx = 0;
  logic [33:0] sb [$];

  axil_reg_if_rd_ext dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_rd_addr(reg_addr), .reg_rd_en(reg_en), .reg_rd_data(reg_data),
    .reg_rd_wait(reg_wait), .reg_rd_ack(reg_ack), .timeout_evt(evt)
  );

  axil_reg_if_rd_ext #(.ALIGN_ADDR(0)) dut_na (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
    .s_axil_arready(na_arready), .s_axil_rdata(na_rdata), .s_axil_rresp(na_rresp),
    .s_axil_rvalid(na_rvalid), .s_axil_rready(rready),
    .reg_rd_addr(na_reg_addr), .reg_rd_en(na_en), .reg_rd_data(reg_data),
    .reg_rd_wait(reg_wait), .reg_rd_ack(reg_ack), .timeout_evt(na_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign reg_data = {16'hCAFE, reg_addr[15:0]};

  // Register model: ack on the ack_at-th cycle of en, wait for the first wait_len cycles
  always begin
    @(posedge clk);
    #1;
    if (!rst_n || !reg_en) en_idx = 0;
    else en_idx++;
    reg_wait = reg_en && (en_idx <= wait_len);
    reg_ack  = reg_en && (ack_at != 0) && (en_idx == ack_at);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (evt) evt_cnt++;
    if (rst_n && rvalid && rready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL r_unexpected: got beat %0h expected none", {rdata, rresp});
      end else begin
        chk("r_beat", {30'd0, rdata, rresp}, {30'd0, sb.pop_front()});
      end
    end
  end

  // Called just after a posedge; returns just after the handshake edge
  task automatic ar(input logic [31:0] a, input logic [33:0] exp, output int hs_cyc);
    int n;
    n = 0;
    sb.push_back(exp);
    araddr  = a;
    arvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!arready && n < 100);
    if (!arready) begin
      total++;
      bad++;
      $display("FAIL ar_handshake: got arready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    hs_cyc  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hs, t, n, e0, seen;

    #12;
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
    chk("rst_en",      {63'd0, reg_en},  64'd0);
    chk("rst_evt",     {63'd0, evt},     64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arready_before_edge", {63'd0, arready}, 64'd0);
    @(negedge clk);
    chk("arready_after_edge", {63'd0, arready}, 64'd1);
    @(posedge clk);
    #1;

    // zero-wait register, minimum latency
    rready = 1'b1;
    ack_at = 1;
    ar(32'h10, {32'hCAFE0010, 2'b00}, hs);
    @(negedge clk);
    chk("t1_en", {63'd0, reg_en}, 64'd1);
    chk("t1_rvalid_early", {63'd0, rvalid}, 64'd0);
    chk("t1_addr", {32'd0, reg_addr}, 64'h10);
    @(negedge clk);
    chk("t1_rvalid", {63'd0, rvalid}, 64'd1);
    idle(3);

    // timeout after 4 en cycles
    ack_at = 0;
    e0 = evt_cnt;
    ar(32'h20, {32'h0, 2'b10}, hs);
    n = 0;
    @(negedge clk);
    while (reg_en && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("t2_en_cycles", 64'(n), 64'd4);
    idle(3);
    chk("t2_evt_pulses", 64'(evt_cnt - e0), 64'd1);

    // long stall then ack
    ack_at = 21;
    wait_len = 20;
    e0 = evt_cnt;
    ar(32'h30, {32'hCAFE0030, 2'b00}, hs);
    idle(30);
    chk("t3_stall_no_evt", 64'(evt_cnt - e0), 64'd0);

    // ack lands on the cycle the counter reaches zero
    ack_at = 4;
    wait_len = 0;
    e0 = evt_cnt;
    ar(32'h34, {32'hCAFE0034, 2'b00}, hs);
    idle(8);
    chk("t3_ack_wins_no_evt", 64'(evt_cnt - e0), 64'd0);

    // FIFO fill under backpressure
    rready = 1'b0;
    ack_at = 1;
    ar(32'h40, {32'hCAFE0040, 2'b00}, hs);
    ar(32'h44, {32'hCAFE0044, 2'b00}, hs);
    araddr = 32'h48;
    arvalid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (arready) seen++;
    end
    chk("t4_ar3_blocked", 64'(seen), 64'd0);
    chk("t4_rvalid_full", {63'd0, rvalid}, 64'd1);
    @(posedge clk);
    #1;
    rready = 1'b1;
    t = cyc;
    ar(32'h48, {32'hCAFE0048, 2'b00}, hs);
    chk("t4_ar3_after_pop", 64'(hs - t), 64'd2);
    idle(4);

    // address alignment on both instances
    ar(32'h13, {32'hCAFE0010, 2'b00}, hs);
    @(negedge clk);
    chk("t5_aligned", {32'd0, reg_addr}, 64'h10);
    chk("t5_unaligned", {32'd0, na_reg_addr}, 64'h13);
    idle(4);

    // asynchronous reset mid-read with one queued response
    rready = 1'b0;
    ack_at = 1;
    ar(32'h50, {32'hCAFE0050, 2'b00}, hs);
    idle(2);
    ack_at = 0;
    ar(32'h54, {32'h0, 2'b10}, hs);
    #2;
    chk("t6_pre_en", {63'd0, reg_en}, 64'd1);
    chk("t6_pre_rvalid", {63'd0, rvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_en_drop", {63'd0, reg_en}, 64'd0);
    chk("t6_rvalid_drop", {63'd0, rvalid}, 64'd0);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    chk("t6_no_stale", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    ack_at = 1;
    ar(32'h58, {32'hCAFE0058, 2'b00}, hs);
    idle(5);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
